// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - EX/MEM consumer: data-memory loads/stores and registered WB slot
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter logic [5:0] INSTR_LB  = 6'd11,
  parameter logic [5:0] INSTR_LH  = 6'd12,
  parameter logic [5:0] INSTR_LW  = 6'd13,
  parameter logic [5:0] INSTR_LBU = 6'd14,
  parameter logic [5:0] INSTR_LHU = 6'd15,
  parameter logic [5:0] INSTR_SB  = 6'd16,
  parameter logic [5:0] INSTR_SH  = 6'd17,
  parameter logic [5:0] INSTR_SW  = 6'd18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [5:0]  instr_id_in,
  input  logic [4:0]  rd_addr_in,
  input  logic        rd_valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] rs2_value_in,
  input  logic [31:0] exec_output_in,
  output logic        stall_out,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_addr,
  output logic        wb_rd_valid,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        trap_valid,
  output logic [31:0] trap_addr
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic [5:0]  op_q;
  logic [1:0]  off_q;
  logic        rd_valid_q;
  logic        is_load, is_store, is_mem, take_trap;
  logic [31:0] st_wdata, load_data;
  logic [3:0]  st_wstrb;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign is_load  = (instr_id_in == INSTR_LB) || (instr_id_in == INSTR_LH) ||
                    (instr_id_in == INSTR_LW) || (instr_id_in == INSTR_LBU) ||
                    (instr_id_in == INSTR_LHU);
  assign is_store = (instr_id_in == INSTR_SB) || (instr_id_in == INSTR_SH) ||
                    (instr_id_in == INSTR_SW);
  assign is_mem   = is_load || is_store;

`ifdef MEM_MISALIGN_TRAP_EN
  assign take_trap = (((instr_id_in == INSTR_LH) || (instr_id_in == INSTR_LHU) ||
                       (instr_id_in == INSTR_SH)) && mem_addr_in[0]) ||
                     (((instr_id_in == INSTR_LW) || (instr_id_in == INSTR_SW)) &&
                      (mem_addr_in[1:0] != 2'b00));
`else
  assign take_trap = 1'b0;
`endif

  // Store lanes: data replicated, strobes select the addressed byte/half.
  always_comb begin
    st_wdata = rs2_value_in;
    st_wstrb = 4'hF;
    if (instr_id_in == INSTR_SB) begin
      st_wdata = {4{rs2_value_in[7:0]}};
      st_wstrb = 4'b0001 << mem_addr_in[1:0];
    end else if (instr_id_in == INSTR_SH) begin
      st_wdata = {2{rs2_value_in[15:0]}};
      st_wstrb = 4'b0011 << {mem_addr_in[1], 1'b0};
    end
  end

  always_comb begin
    lane_b = 8'(dmem_rdata >> {off_q, 3'b000});
    lane_h = 16'(dmem_rdata >> {off_q[1], 4'b0000});
    case (op_q)
      INSTR_LB:  load_data = {{24{lane_b[7]}}, lane_b};
      INSTR_LBU: load_data = {24'h0, lane_b};
      INSTR_LH:  load_data = {{16{lane_h[15]}}, lane_h};
      INSTR_LHU: load_data = {16'h0, lane_h};
      default:   load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (valid_in && is_mem) state_nxt = take_trap ? DONE : REQ;
      REQ:  if (dmem_req_ready)     state_nxt = dmem_we ? DONE : WAIT;
      WAIT: if (dmem_rvalid)        state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // DONE releases the stall so EX/MEM advances past the finished access.
  always_comb begin
    stall_out      = 1'b0;
    dmem_req_valid = 1'b0;
    case (state)
      IDLE: stall_out = rst_n && valid_in && is_mem;
      REQ: begin
        stall_out      = 1'b1;
        dmem_req_valid = 1'b1;
      end
      WAIT: stall_out = 1'b1;
      default: stall_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'h0;
      dmem_wdata  <= 32'h0;
      dmem_wstrb  <= 4'h0;
      op_q        <= 6'h0;
      off_q       <= 2'b00;
      rd_valid_q  <= 1'b0;
      wb_valid    <= 1'b0;
      wb_rd_addr  <= 5'h0;
      wb_rd_valid <= 1'b0;
      wb_data     <= 32'h0;
      wb_pc       <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_valid  <= 1'b0;
      trap_addr   <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          wb_valid <= 1'b0;
          if (valid_in && !is_mem) begin
            wb_valid    <= 1'b1;
            wb_rd_addr  <= rd_addr_in;
            wb_rd_valid <= rd_valid_in;
            wb_data     <= exec_output_in;
            wb_pc       <= pc_in;
          end else if (valid_in && is_mem) begin
            wb_rd_addr  <= rd_addr_in;
            wb_pc       <= pc_in;
            wb_rd_valid <= 1'b0;
            rd_valid_q  <= rd_valid_in && is_load;
            op_q        <= instr_id_in;
            off_q       <= mem_addr_in[1:0];
            if (take_trap) begin
              wb_valid   <= 1'b1;
              wb_data    <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
              trap_valid <= 1'b1;
              trap_addr  <= mem_addr_in;
`endif
            end else begin
              dmem_we    <= is_store;
              dmem_addr  <= {mem_addr_in[31:2], 2'b00};
              dmem_wdata <= is_store ? st_wdata : 32'h0;
              dmem_wstrb <= is_store ? st_wstrb : 4'h0;
            end
          end
        end
        REQ: if (dmem_req_ready && dmem_we) begin
          wb_valid    <= 1'b1;
          wb_rd_valid <= 1'b0;
          wb_data     <= 32'h0;
        end
        WAIT: if (dmem_rvalid) begin
          wb_valid    <= 1'b1;
          wb_rd_valid <= rd_valid_q;
          wb_data     <= load_data;
        end
        default: begin
          wb_valid   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          trap_valid <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed vector bench for mem_access_unit (MEM_MISALIGN_TRAP_EN aware)
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [5:0]  instr_id_in;
  logic [4:0]  rd_addr_in;
  logic        rd_valid_in;
  logic [31:0] pc_in, mem_addr_in, rs2_value_in, exec_output_in;
  logic        stall_out, dmem_req_valid, dmem_req_ready, dmem_we, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_valid, wb_rd_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data, wb_pc;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        trap_valid;
  logic [31:0] trap_addr;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .instr_id_in(instr_id_in),
    .rd_addr_in(rd_addr_in), .rd_valid_in(rd_valid_in), .pc_in(pc_in),
    .mem_addr_in(mem_addr_in), .rs2_value_in(rs2_value_in), .exec_output_in(exec_output_in),
    .stall_out(stall_out), .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_rd_addr(wb_rd_addr), .wb_rd_valid(wb_rd_valid), .wb_data(wb_data), .wb_pc(wb_pc)
`ifdef MEM_MISALIGN_TRAP_EN
    , .trap_valid(trap_valid), .trap_addr(trap_addr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  id;
    logic [4:0]  rd;
    logic        rd_valid;
    logic [31:0] pc, addr, rs2, exec, rdata;
    int          ready_wait;
    logic        is_mem, is_store;
    logic [31:0] exp_data, exp_daddr, exp_wdata;
    logic [3:0]  exp_wstrb;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] id, input logic [4:0] rd, input logic rdv,
                       input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [31:0] ex);
    valid_in = 1'b1; instr_id_in = id; rd_addr_in = rd; rd_valid_in = rdv;
    pc_in = pc; mem_addr_in = addr; rs2_value_in = rs2; exec_output_in = ex;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.id, v.rd, v.rd_valid, v.pc, v.addr, v.rs2, v.exec);
    dmem_req_ready = 1'b0; dmem_rvalid = 1'b0;
    #1 chk($sformatf("v%0d_stall_idle", idx), {31'h0, stall_out}, {31'h0, v.is_mem});
    if (!v.is_mem) begin
      @(negedge clk);
      valid_in = 1'b0;
      #1;
      chk($sformatf("v%0d_wb_valid", idx), {31'h0, wb_valid}, 32'h1);
      chk($sformatf("v%0d_wb_rd_addr", idx), {27'h0, wb_rd_addr}, {27'h0, v.rd});
      chk($sformatf("v%0d_wb_rd_valid", idx), {31'h0, wb_rd_valid}, {31'h0, v.rd_valid});
      chk($sformatf("v%0d_wb_data", idx), wb_data, v.exp_data);
      chk($sformatf("v%0d_wb_pc", idx), wb_pc, v.pc);
    end else begin
      for (int k = 0; k <= v.ready_wait; k++) begin
        @(negedge clk);
        chk($sformatf("v%0d_req_valid_%0d", idx, k), {31'h0, dmem_req_valid}, 32'h1);
        chk($sformatf("v%0d_req_addr_%0d", idx, k), dmem_addr, v.exp_daddr);
        chk($sformatf("v%0d_req_we_%0d", idx, k), {31'h0, dmem_we}, {31'h0, v.is_store});
        chk($sformatf("v%0d_req_wstrb_%0d", idx, k), {28'h0, dmem_wstrb}, {28'h0, v.exp_wstrb});
        if (v.is_store) chk($sformatf("v%0d_req_wdata_%0d", idx, k), dmem_wdata, v.exp_wdata);
        chk($sformatf("v%0d_req_stall_%0d", idx, k), {31'h0, stall_out}, 32'h1);
        dmem_req_ready = (k == v.ready_wait);
      end
      @(negedge clk);
      dmem_req_ready = 1'b0;
      if (!v.is_store) begin
        chk($sformatf("v%0d_wait_req", idx), {31'h0, dmem_req_valid}, 32'h0);
        chk($sformatf("v%0d_wait_stall", idx), {31'h0, stall_out}, 32'h1);
        chk($sformatf("v%0d_wait_wb", idx), {31'h0, wb_valid}, 32'h0);
        dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = 32'h5A5A_5A5A;
        #1 chk($sformatf("v%0d_wb_data", idx), wb_data, v.exp_data);
      end
      chk($sformatf("v%0d_done_wb_valid", idx), {31'h0, wb_valid}, 32'h1);
      chk($sformatf("v%0d_done_rd_valid", idx), {31'h0, wb_rd_valid},
          {31'h0, v.is_store ? 1'b0 : v.rd_valid});
      chk($sformatf("v%0d_done_rd_addr", idx), {27'h0, wb_rd_addr}, {27'h0, v.rd});
      chk($sformatf("v%0d_done_pc", idx), wb_pc, v.pc);
      chk($sformatf("v%0d_done_stall", idx), {31'h0, stall_out}, 32'h0);
      @(negedge clk);
      valid_in = 1'b0;
      #1;
      chk($sformatf("v%0d_no_reaccept", idx), {31'h0, dmem_req_valid}, 32'h0);
      chk($sformatf("v%0d_wb_single", idx), {31'h0, wb_valid}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; dmem_req_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h5A5A_5A5A;
    drive(6'd13, 5'd1, 1'b1, 32'h10, 32'h20, 32'h0, 32'h0);

    //              id     rd     rdv   pc          addr        rs2           exec          rdata         rw mem st  exp_data      daddr       wdata         wstrb
    vecs.push_back('{6'd1,  5'd5,  1'b1, 32'h40, 32'h0,   32'h0,        32'h0000_1234, 32'h0,        0, 1'b0, 1'b0, 32'h0000_1234, 32'h0,   32'h0,        4'h0});
    vecs.push_back('{6'd2,  5'd7,  1'b0, 32'h44, 32'h0,   32'h0,        32'hDEAD_BEEF, 32'h0,        0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0,   32'h0,        4'h0});
    vecs.push_back('{6'd11, 5'd3,  1'b1, 32'h48, 32'h103, 32'h0,        32'h0,         32'h80FF_FF00, 0, 1'b1, 1'b0, 32'hFFFF_FF80, 32'h100, 32'h0,        4'h0});
    vecs.push_back('{6'd14, 5'd4,  1'b1, 32'h4C, 32'h101, 32'h0,        32'h0,         32'h0000_F000, 0, 1'b1, 1'b0, 32'h0000_00F0, 32'h100, 32'h0,        4'h0});
    vecs.push_back('{6'd12, 5'd6,  1'b1, 32'h50, 32'h202, 32'h0,        32'h0,         32'h8001_1234, 1, 1'b1, 1'b0, 32'hFFFF_8001, 32'h200, 32'h0,        4'h0});
    vecs.push_back('{6'd15, 5'd8,  1'b1, 32'h54, 32'h200, 32'h0,        32'h0,         32'h1234_9ABC, 0, 1'b1, 1'b0, 32'h0000_9ABC, 32'h200, 32'h0,        4'h0});
    vecs.push_back('{6'd13, 5'd9,  1'b1, 32'h58, 32'h30C, 32'h0,        32'h0,         32'hCAFE_F00D, 2, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h30C, 32'h0,        4'h0});
    vecs.push_back('{6'd14, 5'd11, 1'b1, 32'h5C, 32'h104, 32'h0,        32'h0,         32'h1234_56AB, 0, 1'b1, 1'b0, 32'h0000_00AB, 32'h104, 32'h0,        4'h0});
    vecs.push_back('{6'd17, 5'd12, 1'b1, 32'h60, 32'h102, 32'h0000_ABCD, 32'h0,        32'h0,        3, 1'b1, 1'b1, 32'h0,         32'h100, 32'hABCD_ABCD, 4'hC});
    vecs.push_back('{6'd16, 5'd13, 1'b1, 32'h64, 32'h402, 32'h1122_3344, 32'h0,        32'h0,        0, 1'b1, 1'b1, 32'h0,         32'h400, 32'h4444_4444, 4'h4});
    vecs.push_back('{6'd18, 5'd14, 1'b0, 32'h68, 32'h500, 32'h89AB_CDEF, 32'h0,        32'h0,        0, 1'b1, 1'b1, 32'h0,         32'h500, 32'h89AB_CDEF, 4'hF});
`ifndef MEM_MISALIGN_TRAP_EN
    vecs.push_back('{6'd13, 5'd15, 1'b1, 32'h6C, 32'h201, 32'h0,        32'h0,         32'h1357_9BDF, 0, 1'b1, 1'b0, 32'h1357_9BDF, 32'h200, 32'h0,        4'h0});
    vecs.push_back('{6'd17, 5'd16, 1'b0, 32'h70, 32'h103, 32'h0000_5566, 32'h0,        32'h0,        0, 1'b1, 1'b1, 32'h0,         32'h100, 32'h5566_5566, 4'hC});
`endif

    // Reset state, with a load presented to prove stall_out is held low.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'h0, stall_out}, 32'h0);
    chk("rst_req_valid", {31'h0, dmem_req_valid}, 32'h0);
    chk("rst_dmem", {dmem_we, dmem_wstrb, 27'h0} | dmem_addr | dmem_wdata, 32'h0);
    chk("rst_wb", {wb_valid, wb_rd_valid, wb_rd_addr, 25'h0} | wb_data | wb_pc, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("rst_trap", {31'h0, trap_valid} | trap_addr, 32'h0);
`endif
    valid_in = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Load followed by ADD: ADD enters only after DONE and retires once.
    @(negedge clk);
    drive(6'd13, 5'd9, 1'b1, 32'h100, 32'h600, 32'h0, 32'h0);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    chk("b2b_req", {31'h0, dmem_req_valid}, 32'h1);
    @(negedge clk);
    dmem_req_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    chk("b2b_wait_stall", {31'h0, stall_out}, 32'h1);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("b2b_lw_data", wb_data, 32'h0BAD_F00D);
    chk("b2b_lw_valid", {31'h0, wb_valid}, 32'h1);
    @(negedge clk);
    drive(6'd1, 5'd10, 1'b1, 32'h104, 32'h0, 32'h0, 32'h77);
    #1;
    chk("b2b_add_stall", {31'h0, stall_out}, 32'h0);
    chk("b2b_gap_wb", {31'h0, wb_valid}, 32'h0);
    chk("b2b_gap_req", {31'h0, dmem_req_valid}, 32'h0);
    @(negedge clk);
    valid_in = 1'b0;
    chk("b2b_add_valid", {31'h0, wb_valid}, 32'h1);
    chk("b2b_add_data", wb_data, 32'h77);
    chk("b2b_add_pc", wb_pc, 32'h104);
    @(negedge clk);
    chk("b2b_add_once", {31'h0, wb_valid}, 32'h0);

    // Reset during REQ drops req_valid without waiting for a clock.
    @(negedge clk);
    drive(6'd13, 5'd2, 1'b1, 32'h200, 32'h700, 32'h0, 32'h0);
    @(negedge clk);
    chk("rreq_req", {31'h0, dmem_req_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rreq_async_drop", {31'h0, dmem_req_valid}, 32'h0);
    chk("rreq_stall", {31'h0, stall_out}, 32'h0);
    valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during WAIT; a late response must not produce a writeback.
    @(negedge clk);
    drive(6'd13, 5'd2, 1'b1, 32'h204, 32'h704, 32'h0, 32'h0);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    dmem_req_ready = 1'b0;
    chk("rwait_stall", {31'h0, stall_out}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rwait_stall_rst", {31'h0, stall_out}, 32'h0);
    valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("rwait_no_wb", {31'h0, wb_valid}, 32'h0);
    chk("rwait_wb_data", wb_data, 32'h0);
    chk("rwait_no_req", {31'h0, dmem_req_valid}, 32'h0);
    @(negedge clk);
    chk("rwait_no_wb2", {31'h0, wb_valid}, 32'h0);

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned LW traps straight to DONE with no bus request.
    @(negedge clk);
    drive(6'd13, 5'd4, 1'b1, 32'h300, 32'h201, 32'h0, 32'h0);
    #1;
    chk("trap_stall", {31'h0, stall_out}, 32'h1);
    @(negedge clk);
    chk("trap_valid", {31'h0, trap_valid}, 32'h1);
    chk("trap_addr", trap_addr, 32'h201);
    chk("trap_no_req", {31'h0, dmem_req_valid}, 32'h0);
    chk("trap_wb_valid", {31'h0, wb_valid}, 32'h1);
    chk("trap_wb_rdv", {31'h0, wb_rd_valid}, 32'h0);
    chk("trap_done_stall", {31'h0, stall_out}, 32'h0);
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    chk("trap_one_cycle", {31'h0, trap_valid}, 32'h0);
    chk("trap_no_req2", {31'h0, dmem_req_valid}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
